// File: rtl/axil_master_arbiter.sv
// Two-requester front end onto a single AXI4-Lite master port.
// Round-robin grant, one transaction in flight, 1-cycle response pulse per requester.
module axil_master_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    req0_valid,
  output logic                    req0_ready,
  input  logic                    req0_we,
  input  logic [ADDR_WIDTH-1:0]   req0_addr,
  input  logic [DATA_WIDTH-1:0]   req0_wdata,
  output logic                    rsp0_valid,
  output logic [DATA_WIDTH-1:0]   rsp0_rdata,
  output logic [1:0]              rsp0_resp,
  input  logic                    req1_valid,
  output logic                    req1_ready,
  input  logic                    req1_we,
  input  logic [ADDR_WIDTH-1:0]   req1_addr,
  input  logic [DATA_WIDTH-1:0]   req1_wdata,
  output logic                    rsp1_valid,
  output logic [DATA_WIDTH-1:0]   rsp1_rdata,
  output logic [1:0]              rsp1_resp,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]              m_axi_arprot,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_WRESP, S_RADDR, S_RDATA, S_DONE} state_t;

  state_t                         r_state;
  logic                           r_last_grant;
  logic                           r_gnt_id;
  logic [ADDR_WIDTH-1:0]          r_addr;
  logic [DATA_WIDTH-1:0]          r_wdata;
  logic [DATA_WIDTH/8-1:0]        r_wstrb;
  logic [1:0]                     r_req_ready;
  logic [1:0]                     r_rsp_valid;
  logic [1:0][DATA_WIDTH-1:0]     r_rsp_rdata;
  logic [1:0][1:0]                r_rsp_resp;
  logic                           r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
  logic                           r_issued, r_aw_done, r_w_done;

  logic                           w_any_req;
  logic                           w_gnt_id;
  logic                           w_sel_we;
  logic [ADDR_WIDTH-1:0]          w_sel_addr;
  logic [DATA_WIDTH-1:0]          w_sel_wdata;

  // Contention goes to whoever did not win last; a lone requester always wins.
  always_comb begin
    w_gnt_id = 1'b0;
    if (req0_valid && req1_valid) w_gnt_id = ~r_last_grant;
    else if (req1_valid)          w_gnt_id = 1'b1;
  end

  assign w_any_req   = req0_valid | req1_valid;
  assign w_sel_we    = w_gnt_id ? req1_we    : req0_we;
  assign w_sel_addr  = w_gnt_id ? req1_addr  : req0_addr;
  assign w_sel_wdata = w_gnt_id ? req1_wdata : req0_wdata;

  // Each channel state raises its valid/ready one cycle after entry, keeping
  // every AXI output a pure register with no path from AXI inputs.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_gnt_id     <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_req_ready  <= '0;
      r_rsp_valid  <= '0;
      r_rsp_rdata  <= '0;
      r_rsp_resp   <= '0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_bready     <= 1'b0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_issued     <= 1'b0;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
    end else begin
      r_req_ready <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_gnt_id              <= w_gnt_id;
            r_req_ready[w_gnt_id] <= 1'b1;
            r_addr                <= w_sel_addr;
            r_wdata               <= w_sel_wdata;
            r_wstrb               <= '1;
            r_issued              <= 1'b0;
            r_aw_done             <= 1'b0;
            r_w_done              <= 1'b0;
            r_state               <= w_sel_we ? S_WRITE : S_RADDR;
          end
        end
        S_WRITE: begin
          if (!r_issued) begin
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_issued  <= 1'b1;
          end else if (r_aw_done && r_w_done) begin
            r_state <= S_WRESP;
          end else begin
            if (r_awvalid && m_axi_awready) begin
              r_awvalid <= 1'b0;
              r_aw_done <= 1'b1;
            end
            if (r_wvalid && m_axi_wready) begin
              r_wvalid <= 1'b0;
              r_w_done <= 1'b1;
            end
          end
        end
        S_WRESP: begin
          if (!r_bready) begin
            r_bready <= 1'b1;
          end else if (m_axi_bvalid) begin
            r_bready              <= 1'b0;
            r_rsp_valid[r_gnt_id] <= 1'b1;
            r_rsp_rdata[r_gnt_id] <= '0;
            r_rsp_resp[r_gnt_id]  <= m_axi_bresp;
            r_state               <= S_DONE;
          end
        end
        S_RADDR: begin
          if (!r_issued) begin
            r_arvalid <= 1'b1;
            r_issued  <= 1'b1;
          end else if (m_axi_arready) begin
            r_arvalid <= 1'b0;
            r_state   <= S_RDATA;
          end
        end
        S_RDATA: begin
          if (!r_rready) begin
            r_rready <= 1'b1;
          end else if (m_axi_rvalid) begin
            r_rready              <= 1'b0;
            r_rsp_valid[r_gnt_id] <= 1'b1;
            r_rsp_rdata[r_gnt_id] <= m_axi_rdata;
            r_rsp_resp[r_gnt_id]  <= m_axi_rresp;
            r_state               <= S_DONE;
          end
        end
        S_DONE: begin
          r_rsp_valid  <= '0;
          r_rsp_rdata  <= '0;
          r_rsp_resp   <= '0;
          r_last_grant <= r_gnt_id;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req0_ready    = r_req_ready[0];
  assign req1_ready    = r_req_ready[1];
  assign rsp0_valid    = r_rsp_valid[0];
  assign rsp1_valid    = r_rsp_valid[1];
  assign rsp0_rdata    = r_rsp_rdata[0];
  assign rsp1_rdata    = r_rsp_rdata[1];
  assign rsp0_resp     = r_rsp_resp[0];
  assign rsp1_resp     = r_rsp_resp[1];

  assign m_axi_awaddr  = r_addr;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_wdata   = r_wdata;
  assign m_axi_wstrb   = r_wstrb;
  assign m_axi_wvalid  = r_wvalid;
  assign m_axi_bready  = r_bready;
  assign m_axi_araddr  = r_addr;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = r_arvalid;
  assign m_axi_rready  = r_rready;

endmodule
